inducer_input_conditioner: RTL and testbench

Upstream front end for the 3-input combinational logic gates (in1, in2, in3 truth-table modules). It takes three raw, asynchronous sensor/inducer signals and does three things: synchronises them, debounces them per channel, and presents stable in1/in2/in3 levels to the gate. It also publishes every stable-vector change through a valid/ready event port for logging or downstream sequencing.

---
 rtl/inducer_input_conditioner_pkg.sv | 13 +
 rtl/inducer_input_conditioner_debounce.sv | 57 +++++
 rtl/inducer_input_conditioner.sv | 88 ++++++++
 tb/tb_inducer_input_conditioner.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/inducer_input_conditioner_pkg.sv
// Types and channel map shared by the input conditioner and the truth-table gate wrappers.
package inducer_input_conditioner_pkg;

  localparam int NUM_IN = 3;

  // Packed as {in1, in2, in3}.
  typedef logic [NUM_IN-1:0] in_vec_t;

  localparam int CH_IN1 = 2;
  localparam int CH_IN2 = 1;
  localparam int CH_IN3 = 0;

endpackage

// File: rtl/inducer_input_conditioner_debounce.sv
// One raw input channel: two-flop synchroniser, mismatch counter and stable flop.
module input_debounce_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic stable_o,
  output logic stable_next_o,
  output logic upd_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // upd_o flags the cycle whose closing edge flips stable_q, so the top can
  // capture stable_next_o on that same edge.
  always_comb begin
    sync1_d  = raw_i;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    upd_o    = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      upd_o    = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o      = stable_q;
  assign stable_next_o = stable_d;

endmodule

// File: rtl/inducer_input_conditioner.sv
// Debounced in1/in2/in3 levels plus a coalescing valid/ready change-event port.
module inducer_input_conditioner
  import inducer_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] raw_in,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       vec_valid,
  input  logic       vec_ready,
  output logic [2:0] vec_data,
  output logic       vec_dropped,
  input  logic       clr_dropped,
  output logic [7:0] event_cnt
);

  in_vec_t           stable_vec;
  in_vec_t           next_vec;
  logic [NUM_IN-1:0] upd;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
    input_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .raw_i         (raw_in[i]),
      .stable_o      (stable_vec[i]),
      .stable_next_o (next_vec[i]),
      .upd_o         (upd[i])
    );
  end

  logic    ev;
  logic    vec_valid_q, vec_valid_d;
  in_vec_t vec_data_q, vec_data_d;
  logic    vec_dropped_q, vec_dropped_d;
  logic [7:0] event_cnt_q, event_cnt_d;

  assign ev = |upd;

  // A drop is only an event landing on a pending, unaccepted vector; the set
  // is applied after the clear so it wins when both happen together.
  always_comb begin
    vec_valid_d   = vec_valid_q;
    vec_data_d    = vec_data_q;
    vec_dropped_d = vec_dropped_q;
    event_cnt_d   = event_cnt_q;
    if (clr_dropped) vec_dropped_d = 1'b0;
    if (ev) begin
      vec_data_d  = next_vec;
      vec_valid_d = 1'b1;
      event_cnt_d = event_cnt_q + 8'd1;
      if (vec_valid_q && !vec_ready) vec_dropped_d = 1'b1;
    end else if (vec_valid_q && vec_ready) begin
      vec_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_valid_q   <= 1'b0;
      vec_data_q    <= '0;
      vec_dropped_q <= 1'b0;
      event_cnt_q   <= '0;
    end else begin
      vec_valid_q   <= vec_valid_d;
      vec_data_q    <= vec_data_d;
      vec_dropped_q <= vec_dropped_d;
      event_cnt_q   <= event_cnt_d;
    end
  end

  assign in1         = stable_vec[CH_IN1];
  assign in2         = stable_vec[CH_IN2];
  assign in3         = stable_vec[CH_IN3];
  assign vec_valid   = vec_valid_q;
  assign vec_data    = vec_data_q;
  assign vec_dropped = vec_dropped_q;
  assign event_cnt   = event_cnt_q;

endmodule

// File: tb/tb_inducer_input_conditioner.sv
// Directed bench for inducer_input_conditioner with a scoreboard of expected event vectors.
module tb_inducer_input_conditioner;
  import inducer_input_conditioner_pkg::*;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] raw_in;
  logic       in1, in2, in3;
  logic       vec_valid;
  logic       vec_ready;
  logic [2:0] vec_data;
  logic       vec_dropped;
  logic       clr_dropped;
  logic [7:0] event_cnt;

  int      checks   = 0;
  int      failures = 0;
  int      exp_cnt  = 0;
  in_vec_t exp_q[$];

  always #5 clk = ~clk;

  inducer_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw_in      (raw_in),
    .in1         (in1),
    .in2         (in2),
    .in3         (in3),
    .vec_valid   (vec_valid),
    .vec_ready   (vec_ready),
    .vec_data    (vec_data),
    .vec_dropped (vec_dropped),
    .clr_dropped (clr_dropped),
    .event_cnt   (event_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: sample mid-cycle (scoreboard pop on a pending transfer), then
  // step past the rising edge where inputs are changed.
  task automatic tick();
    in_vec_t e;
    @(negedge clk);
    if (rst_n && vec_valid && vec_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer", 32'(vec_data), 32'hdead);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_data", 32'(vec_data), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input int max_cycles);
    int k;
    k = 0;
    while (!vec_valid && k < max_cycles) begin
      tick();
      k++;
    end
    chk("wait_valid", 32'(vec_valid), 32'd1);
  endtask

  task automatic drive(input logic [2:0] v, input bit coalesce);
    raw_in = v;
    if (coalesce && exp_q.size() > 0) void'(exp_q.pop_back());
    exp_q.push_back(in_vec_t'(v));
    exp_cnt++;
  endtask

  initial begin
    rst_n = 1'b1; raw_in = 3'b000; vec_ready = 1'b0; clr_dropped = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_in", 32'({in1, in2, in3}), 32'd0);
    chk("rst_valid", 32'(vec_valid), 32'd0);
    chk("rst_cnt", 32'(event_cnt), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_in", 32'({in1, in2, in3}), 32'd0);
      chk("idle_valid", 32'(vec_valid), 32'd0);
      chk("idle_cnt", 32'(event_cnt), 32'd0);
    end

    // Latency: change before edge 0 lands after edge D+1.
    drive(3'b100, 1'b0);
    ticks(D + 1);
    chk("lat_early_in1", 32'(in1), 32'd0);
    chk("lat_early_valid", 32'(vec_valid), 32'd0);
    tick();
    chk("lat_in1", 32'(in1), 32'd1);
    chk("lat_valid", 32'(vec_valid), 32'd1);
    chk("lat_data", 32'(vec_data), 32'b100);
    chk("lat_cnt", 32'(event_cnt), 32'(8'(exp_cnt)));
    vec_ready = 1'b1;
    tick();
    chk("lat_drained", 32'(vec_valid), 32'd0);

    // Glitch of D-1 sampled cycles on channel 0.
    raw_in = 3'b101;
    ticks(D - 1);
    raw_in = 3'b100;
    ticks(D + 4);
    chk("glitch_in3", 32'(in3), 32'd0);
    chk("glitch_valid", 32'(vec_valid), 32'd0);
    chk("glitch_cnt", 32'(event_cnt), 32'(8'(exp_cnt)));

    // Back to 000, then simultaneous 000->011 is a single event.
    drive(3'b000, 1'b0);
    ticks(D + 3);
    drive(3'b011, 1'b0);
    wait_valid(D + 4);
    chk("simul_data", 32'(vec_data), 32'b011);
    chk("simul_cnt", 32'(event_cnt), 32'(8'(exp_cnt)));
    tick();
    chk("simul_single", 32'(vec_valid), 32'd0);
    drive(3'b000, 1'b0);
    ticks(D + 3);

    // Backpressure: 000->001->101 with ready low coalesces and flags a drop.
    vec_ready = 1'b0;
    drive(3'b001, 1'b0);
    ticks(D + 2);
    chk("bp_first_data", 32'(vec_data), 32'b001);
    chk("bp_first_drop", 32'(vec_dropped), 32'd0);
    drive(3'b101, 1'b1);
    ticks(D + 2);
    chk("bp_valid", 32'(vec_valid), 32'd1);
    chk("bp_data", 32'(vec_data), 32'b101);
    chk("bp_drop", 32'(vec_dropped), 32'd1);
    chk("bp_cnt", 32'(event_cnt), 32'(8'(exp_cnt)));
    clr_dropped = 1'b1;
    tick();
    clr_dropped = 1'b0;
    chk("clr_drop", 32'(vec_dropped), 32'd0);
    chk("clr_keep_valid", 32'(vec_valid), 32'd1);
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    chk("bp_drained", 32'(vec_valid), 32'd0);

    // Transfer and new event on the same edge.
    drive(3'b111, 1'b0);
    ticks(D + 2);
    chk("coin_a_data", 32'(vec_data), 32'b111);
    drive(3'b110, 1'b0);
    ticks(D + 1);
    chk("coin_pre_data", 32'(vec_data), 32'b111);
    vec_ready = 1'b1;
    tick();
    chk("coin_valid", 32'(vec_valid), 32'd1);
    chk("coin_data", 32'(vec_data), 32'b110);
    chk("coin_nodrop", 32'(vec_dropped), 32'd0);
    tick();
    chk("coin_drained", 32'(vec_valid), 32'd0);

    // Event counter wraps after 256 events.
    while (exp_cnt < 256) begin
      drive(raw_in ^ 3'b001, 1'b0);
      ticks(D + 2);
    end
    tick();
    chk("wrap_cnt", 32'(event_cnt), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-handshake and mid-debounce clears everything asynchronously.
    vec_ready = 1'b0;
    drive(raw_in ^ 3'b100, 1'b0);
    ticks(D + 2);
    drive(raw_in ^ 3'b100, 1'b1);
    ticks(D + 2);
    chk("pre_rst_drop", 32'(vec_dropped), 32'd1);
    drive(raw_in ^ 3'b010, 1'b1);
    ticks(3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in", 32'({in1, in2, in3}), 32'd0);
    chk("arst_valid", 32'(vec_valid), 32'd0);
    chk("arst_data", 32'(vec_data), 32'd0);
    chk("arst_drop", 32'(vec_dropped), 32'd0);
    chk("arst_cnt", 32'(event_cnt), 32'd0);
    exp_q.delete();
    raw_in = 3'b000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ticks(D + 3);
    chk("post_rst_valid", 32'(vec_valid), 32'd0);
    chk("post_rst_cnt", 32'(event_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
